// File: rtl/sw_target_streamer_if.sv
// sw_target_streamer_if: packed-base word stream from the target buffer into the streamer.
interface sw_target_streamer_if #(
   parameter int BASES_PER_WORD = 16
);
   logic                          word_valid;
   logic                          word_ready;
   logic [2*BASES_PER_WORD-1:0]   word_data;
   modport master (output word_valid, output word_data, input word_ready);
   modport slave (input word_valid, input word_data, output word_ready);
endinterface

// File: rtl/sw_target_streamer.sv
// sw_target_streamer: clears a Smith-Waterman array, serialises target bases into it and captures the score.
module sw_target_streamer #(
   parameter int SCORE_WIDTH    = 12,
   parameter int LENGTH         = 128,
   parameter int LOG_LENGTH     = 7,
   parameter int BASES_PER_WORD = 16,
   parameter int TLEN_WIDTH     = 11,
   parameter int TIMEOUT        = 264,
   parameter logic [SCORE_WIDTH-1:0] ZERO = SCORE_WIDTH'(1) << (SCORE_WIDTH-1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [LOG_LENGTH-1:0]  query_len_i,
   input  logic [TLEN_WIDTH-1:0]  target_len_i,
   sw_target_streamer_if.slave    word_if,
   output logic                   sw_rst_n_o,
   output logic                   sw_en_o,
   output logic [1:0]             sw_data_o,
   output logic [LOG_LENGTH-1:0]  sw_sel_o,
   input  logic                   sw_vld_i,
   input  logic [SCORE_WIDTH-1:0] sw_result_i,
   output logic                   busy_o,
   output logic [SCORE_WIDTH-1:0] score_o,
   output logic                   score_valid_o,
   output logic                   err_o
);
   localparam int CW = $clog2(BASES_PER_WORD + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int BW = 2 * BASES_PER_WORD;

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

   state_t                 state_q, state_d;
   logic [BW-1:0]          buf_q, buf_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [TLEN_WIDTH-1:0]  words_q, words_d;
   logic [TLEN_WIDTH-1:0]  left_q, left_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic [SCORE_WIDTH-1:0] res_q, res_d;
   logic                   rerr_q, rerr_d;
   logic                   sw_rst_n_q, sw_rst_n_d;
   logic                   sw_en_q, sw_en_d;
   logic [1:0]             sw_data_q, sw_data_d;
   logic [LOG_LENGTH-1:0]  sw_sel_q, sw_sel_d;
   logic                   busy_q, busy_d;
   logic [SCORE_WIDTH-1:0] score_q, score_d;
   logic                   score_valid_q, score_valid_d;
   logic                   err_q, err_d;

   logic [TLEN_WIDTH-1:0]  unloaded;
   logic [CW-1:0]          load_n;
   logic                   ready, hs, issue, bad;

   // bases still to be fetched are those not yet issued minus those sitting in the buffer
   assign unloaded = left_q - TLEN_WIDTH'(cnt_q);
   assign load_n   = (unloaded > TLEN_WIDTH'(BASES_PER_WORD)) ? CW'(BASES_PER_WORD) : CW'(unloaded);
   assign ready    = (state_q == STREAM) && (words_q != '0) && (cnt_q <= CW'(1));
   assign hs       = word_if.word_valid && ready;
   assign issue    = (state_q == STREAM) && (cnt_q != '0);
   assign bad      = (query_len_i == '0) || (target_len_i == '0) || (int'(query_len_i) > LENGTH);

   assign word_if.word_ready = ready;
   assign sw_rst_n_d         = (state_d != CLEAR);
   assign busy_d             = (state_d != IDLE);
   assign score_valid_d      = (state_q == DONE);

   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      cnt_d     = cnt_q;
      words_d   = words_q;
      left_d    = left_q;
      tmo_d     = tmo_q;
      res_d     = res_q;
      rerr_d    = rerr_q;
      sw_en_d   = 1'b0;
      sw_data_d = sw_data_q;
      sw_sel_d  = sw_sel_q;
      score_d   = score_q;
      err_d     = err_q;
      case (state_q)
         IDLE: if (start_i) begin
            if (bad) begin
               res_d   = ZERO;
               rerr_d  = 1'b1;
               state_d = DONE;
            end else begin
               left_d   = target_len_i;
               words_d  = TLEN_WIDTH'((32'(target_len_i) + BASES_PER_WORD - 1) / BASES_PER_WORD);
               sw_sel_d = query_len_i;
               cnt_d    = '0;
               tmo_d    = '0;
               state_d  = CLEAR;
            end
         end
         CLEAR: state_d = STREAM;
         STREAM: begin
            if (issue) begin
               sw_en_d   = 1'b1;
               sw_data_d = buf_q[1:0];
               buf_d     = buf_q >> 2;
               cnt_d     = cnt_q - 1'b1;
               left_d    = left_q - 1'b1;
               state_d   = (left_q == TLEN_WIDTH'(1)) ? DRAIN : STREAM;
            end
            // a reload only happens with at most one base left, so it may overwrite the shifted buffer
            if (hs) begin
               buf_d   = word_if.word_data;
               cnt_d   = load_n;
               words_d = words_q - 1'b1;
            end
         end
         DRAIN: begin
            tmo_d = tmo_q + 1'b1;
            if (sw_vld_i) begin
               res_d   = sw_result_i;
               rerr_d  = 1'b0;
               state_d = DONE;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               res_d   = ZERO;
               rerr_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            score_d = res_q;
            err_d   = rerr_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         buf_q         <= '0;
         cnt_q         <= '0;
         words_q       <= '0;
         left_q        <= '0;
         tmo_q         <= '0;
         res_q         <= ZERO;
         rerr_q        <= 1'b0;
         sw_rst_n_q    <= 1'b0;
         sw_en_q       <= 1'b0;
         sw_data_q     <= '0;
         sw_sel_q      <= '0;
         busy_q        <= 1'b0;
         score_q       <= ZERO;
         score_valid_q <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         buf_q         <= buf_d;
         cnt_q         <= cnt_d;
         words_q       <= words_d;
         left_q        <= left_d;
         tmo_q         <= tmo_d;
         res_q         <= res_d;
         rerr_q        <= rerr_d;
         sw_rst_n_q    <= sw_rst_n_d;
         sw_en_q       <= sw_en_d;
         sw_data_q     <= sw_data_d;
         sw_sel_q      <= sw_sel_d;
         busy_q        <= busy_d;
         score_q       <= score_d;
         score_valid_q <= score_valid_d;
         err_q         <= err_d;
      end
   end

   assign sw_rst_n_o    = sw_rst_n_q;
   assign sw_en_o       = sw_en_q;
   assign sw_data_o     = sw_data_q;
   assign sw_sel_o      = sw_sel_q;
   assign busy_o        = busy_q;
   assign score_o       = score_q;
   assign score_valid_o = score_valid_q;
   assign err_o         = err_q;
endmodule

// File: tb/tb_sw_target_streamer.sv
// tb_sw_target_streamer: directed jobs against a base-sequence/score model with per-cycle output checking.
module tb_sw_target_streamer;
   localparam logic [11:0] ZERO = 12'h800;

   logic        clk, rst, start;
   logic [6:0]  qlen;
   logic [10:0] tlen;
   logic        sw_rst_n, sw_en, sw_vld, busy, score_valid, err;
   logic [1:0]  sw_data;
   logic [6:0]  sw_sel;
   logic [11:0] sw_result, score;

   sw_target_streamer_if #(.BASES_PER_WORD(16)) ifc();

   sw_target_streamer dut (
      .clk(clk), .rst(rst), .start_i(start), .query_len_i(qlen), .target_len_i(tlen),
      .word_if(ifc.slave), .sw_rst_n_o(sw_rst_n), .sw_en_o(sw_en), .sw_data_o(sw_data),
      .sw_sel_o(sw_sel), .sw_vld_i(sw_vld), .sw_result_i(sw_result), .busy_o(busy),
      .score_o(score), .score_valid_o(score_valid), .err_o(err)
   );

   int          n_chk, n_fail, cyc, id, sid, n_en, n_hs, n_rdy, n_rstn, n_sv;
   int          first_en, last_en, sv_cyc, exp_len, start_cyc;
   logic [1:0]  exp_b [0:2047];
   logic [11:0] exp_score;
   logic        exp_err;
   logic [31:0] wq [$];
   logic [15:0] obs;
   logic [6:0]  prev_sel;
   bit          tog, ph, hs;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // target model: base k of the job is bits [2k+1:2k] of the concatenated little-endian words
   task automatic load_words(input int L, input logic [31:0] w0, output int nw);
      logic [31:0] w;
      nw = (L + 15) / 16;
      for (int i = 0; i < nw; i++) begin
         w = w0 + 32'(i) * 32'h9E37_79B9;
         wq.push_back(w);
         for (int b = 0; b < 16; b++)
            if (i * 16 + b < L) exp_b[i * 16 + b] = 2'(w >> (2 * b));
      end
   endtask

   task automatic job(input int q, input int L, input logic [31:0] w0, input bit tg,
                      input bit resp, input logic [11:0] res, input bit pulse_busy);
      int nw;
      bit bad;
      bad = (q == 0) || (L == 0) || (q > 128);
      nw = 0;
      if (!bad) load_words(L, w0, nw);
      exp_len   = bad ? 0 : L;
      exp_score = (bad || !resp) ? ZERO : res;
      exp_err   = bad || !resp;
      tog = tg;
      sw_result = res;
      sw_vld = 1'b0;
      @(posedge clk); #1;
      id++;
      start = 1'b1; qlen = 7'(q); tlen = 11'(L); start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      if (pulse_busy) begin
         for (int i = 0; i < 200 && n_en < 3; i++) @(posedge clk);
         #1; start = 1'b1; qlen = 7'd0;
         @(posedge clk); #1; start = 1'b0; qlen = 7'(q);
      end
      if (!bad) begin
         for (int i = 0; i < 2000 && n_en < L; i++) @(posedge clk);
         chk("bases_issued", n_en, L);
         #1;
         if (resp) sw_vld = 1'b1;
      end
      for (int i = 0; i < 600 && n_sv == 0; i++) @(posedge clk);
      #1;
      sw_vld = 1'b0;
      tick(2);
      chk("sv_pulses", n_sv, 1);
      chk("en_pulses", n_en, exp_len);
      chk("words_taken", n_hs, nw);
      chk("clear_cycles", n_rstn, bad ? 0 : 1);
      chk("sel", sw_sel, bad ? prev_sel : 7'(q));
      if (!bad) prev_sel = 7'(q);
      chk("score_held", score, exp_score);
      chk("busy_idle", busy, 0);
      if (bad) begin
         chk("reject_latency", sv_cyc - start_cyc, 2);
         chk("ready_cycles", n_rdy, 0);
      end else begin
         chk("first_en_latency", first_en - start_cyc, 4);
         chk("drain_latency", sv_cyc - last_en, resp ? 3 : 265);
         if (!tg) chk("gapless", last_en - first_en, L - 1);
      end
   endtask

   initial begin
      int nw;
      rst = 1'b1; start = 1'b0; qlen = '0; tlen = '0; sw_vld = 1'b0; sw_result = '0;
      ifc.word_valid = 1'b0; ifc.word_data = '0;
      n_chk = 0; n_fail = 0; cyc = 0; id = 0; sid = 0; tog = 1'b0; ph = 1'b0; hs = 1'b0;
      n_en = 0; n_hs = 0; n_rdy = 0; n_rstn = 0; n_sv = 0; first_en = 0; last_en = 0; sv_cyc = 0;
      exp_len = 0; exp_score = ZERO; exp_err = 1'b0; prev_sel = '0; obs = '0;
      fork
         forever begin
            @(posedge clk);
            cyc++;
         end
         forever begin
            @(negedge clk);
            if (id != sid) begin
               sid = id; n_en = 0; n_hs = 0; n_rdy = 0; n_rstn = 0; n_sv = 0; obs = '0;
            end
            if (!rst) begin
               if (sw_en) begin
                  if (n_en < exp_len) chk("sw_data", sw_data, exp_b[n_en]);
                  else chk("extra_base", n_en + 1, exp_len);
                  chk("busy_streaming", busy, 1);
                  if (n_en < 8) obs[2 * n_en +: 2] = sw_data;
                  if (n_en == 0) first_en = cyc;
                  last_en = cyc;
                  n_en++;
               end
               if (ifc.word_valid && ifc.word_ready) n_hs++;
               if (ifc.word_ready) n_rdy++;
               if (!sw_rst_n) n_rstn++;
               if (score_valid) begin
                  n_sv++;
                  sv_cyc = cyc;
                  chk("score", score, exp_score);
                  chk("err", err, exp_err);
                  chk("busy_at_sv", busy, 0);
               end
            end
         end
         forever begin
            @(negedge clk);
            hs = ifc.word_valid && ifc.word_ready && !rst;
            @(posedge clk); #1;
            if (hs && wq.size() > 0) void'(wq.pop_front());
            ph = !ph;
            ifc.word_valid = (wq.size() > 0) && (!tog || ph);
            ifc.word_data  = (wq.size() > 0) ? wq[0] : 32'h0;
         end
      join_none

      repeat (3) @(negedge clk);
      chk("rst_sw_rst_n", sw_rst_n, 0);
      chk("rst_score", score, 12'h800);
      rst = 1'b0;
      tick(1);
      chk("idle_sw_rst_n", sw_rst_n, 1);
      chk("idle_busy", busy, 0);
      chk("idle_score", score, 12'h800);
      chk("idle_sw_en", sw_en, 0);
      chk("idle_ready", ifc.word_ready, 0);

      job(4, 5, 32'h0000_00E4, 1'b0, 1'b1, 12'h80A, 1'b0);
      chk("job1_bases", obs[9:0], 10'h0E4);
      chk("job1_score", score, 12'h80A);
      chk("job1_err", err, 0);
      chk("job1_sel", sw_sel, 7'd4);
      job(0, 10, 32'h0, 1'b0, 1'b1, 12'h111, 1'b0);
      chk("qlen0_err", err, 1);
      job(100, 40, 32'hCAFE_F00D, 1'b1, 1'b1, 12'h7F0, 1'b0);
      chk("tog_words", n_hs, 3);
      chk("tog_bases", n_en, 40);
      job(127, 40, 32'h0BAD_BEEF, 1'b0, 1'b1, 12'h123, 1'b0);

      load_words(40, 32'h1234_5678, nw);
      exp_len = 40; tog = 1'b0;
      @(posedge clk); #1;
      id++; start = 1'b1; qlen = 7'd20; tlen = 11'd40;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 200 && n_en < 10; i++) @(posedge clk);
      chk("abort_progress", n_en, 10);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("async_sw_rst_n", sw_rst_n, 0);
      chk("async_sw_en", sw_en, 0);
      chk("async_busy", busy, 0);
      chk("async_score", score, 12'h800);
      chk("async_sv", score_valid, 0);
      chk("async_ready", ifc.word_ready, 0);
      chk("async_sel", sw_sel, 0);
      wq.delete();
      ifc.word_valid = 1'b0;
      prev_sel = '0;
      tick(2);
      @(negedge clk);
      rst = 1'b0;
      tick(5);
      chk("abort_no_sv", n_sv, 0);

      job(8, 33, 32'h5555_AAAA, 1'b0, 1'b1, 12'hABC, 1'b1);
      job(3, 0, 32'h0, 1'b0, 1'b1, 12'h222, 1'b0);
      job(5, 17, 32'h0F0F_3C3C, 1'b0, 1'b0, 12'h333, 1'b0);
      chk("timeout_score", score, 12'h800);
      chk("timeout_err", err, 1);
      job(1, 16, 32'hFFFF_0000, 1'b0, 1'b1, 12'h801, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
